// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a bit period programmable in clock cycles.
// One byte and one period are captured per accepted request; all outputs are registered.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 12
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  input  logic [CNT_W-1:0]     i_Clk_per_bit,
  output logic                 o_TX_Active_L,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       cnt_last;
  logic [DATA_BITS-1:0]   tx_byte;
  logic [IDX_W-1:0]       bit_idx;
  logic [CNT_W-1:0]       accept_last;
  logic [IDX_W-1:0]       next_idx;
  logic                   bit_end;

  // A programmed period of 0 behaves like 1, so the terminal count is N-1 clamped at 0.
  assign accept_last = (i_Clk_per_bit == '0) ? '0 : i_Clk_per_bit - CNT_W'(1);
  assign next_idx    = bit_idx + IDX_W'(1);
  assign bit_end     = (bit_cnt == cnt_last);

  // CLEANUP shares the accept path with IDLE: its exit edge may start the next
  // frame, giving back-to-back frames a single idle-high clock between them.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      cnt_last      <= '0;
      tx_byte       <= '0;
      bit_idx       <= '0;
      o_TX_Serial   <= 1'b1;
      o_TX_Active_L <= 1'b1;
      o_TX_Done     <= 1'b0;
    end else begin
      case (state)
        IDLE, CLEANUP: begin
          o_TX_Done <= 1'b0;
          if (i_TX_DV) begin
            tx_byte       <= i_TX_Byte;
            cnt_last      <= accept_last;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            o_TX_Serial   <= 1'b0;
            o_TX_Active_L <= 1'b0;
            state         <= START;
          end else begin
            o_TX_Serial   <= 1'b1;
            o_TX_Active_L <= 1'b1;
            state         <= IDLE;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt     <= '0;
            bit_idx     <= '0;
            o_TX_Serial <= tx_byte[0];
            state       <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == LAST_IDX) begin
              o_TX_Serial <= 1'b1;
              state       <= STOP;
            end else begin
              bit_idx     <= next_idx;
              o_TX_Serial <= tx_byte[next_idx];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt       <= '0;
            o_TX_Active_L <= 1'b1;
            o_TX_Done     <= 1'b1;
            state         <= CLEANUP;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          o_TX_Serial   <= 1'b1;
          o_TX_Active_L <= 1'b1;
          o_TX_Done     <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: requests push expected frames, a monitor checks
// every line sample against them as the DUT transmits.
module tb_uart_tx;

  logic        i_Clock;
  logic        i_Rst_L;
  logic        i_TX_DV;
  logic [7:0]  i_TX_Byte;
  logic [11:0] i_Clk_per_bit;
  logic        o_TX_Active_L;
  logic        o_TX_Serial;
  logic        o_TX_Done;

  typedef struct {
    logic [9:0] pattern;
    int         n;
    int         start_cyc;
    int         abort;
  } exp_frame_t;

  exp_frame_t exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         in_frame = 0;

  uart_tx #(.DATA_BITS(8), .CNT_W(12)) dut (
    .i_Clock      (i_Clock),
    .i_Rst_L      (i_Rst_L),
    .i_TX_DV      (i_TX_DV),
    .i_TX_Byte    (i_TX_Byte),
    .i_Clk_per_bit(i_Clk_per_bit),
    .o_TX_Active_L(o_TX_Active_L),
    .o_TX_Serial  (o_TX_Serial),
    .o_TX_Done    (o_TX_Done)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;
  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Issue one request; the accept edge is the next rising edge, so its cycle is cyc+1.
  task automatic apply_stimulus(input logic [7:0] data, input logic [11:0] cpb, input int dv_cycles,
                                input logic [9:0] pattern, input int n_eff, input int abort);
    exp_frame_t e;
    @(posedge i_Clock);
    #1;
    i_TX_Byte     = data;
    i_Clk_per_bit = cpb;
    i_TX_DV       = 1'b1;
    e.pattern   = pattern;
    e.n         = n_eff;
    e.start_cyc = cyc + 1;
    e.abort     = abort;
    exp_q.push_back(e);
    repeat (dv_cycles) @(posedge i_Clock);
    #1;
    i_TX_DV = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge i_Clock);
      #1;
      if (exp_q.size() == 0 && !in_frame) break;
    end
    if (k >= bound) check_output("wait_idle_timeout", 1, 0);
  endtask

  // Each bit must hold its level for exactly n samples with busy asserted and no Done.
  task automatic run_frame(input exp_frame_t e);
    int matched;
    bit aborted;
    aborted = 0;
    check_output("start_cycle", cyc, e.start_cyc);
    for (int b = 0; b < 10; b++) begin
      matched = 0;
      for (int j = 0; j < e.n; j++) begin
        if (!(b == 0 && j == 0)) @(negedge i_Clock);
        if (!i_Rst_L) begin
          aborted = 1;
          break;
        end
        if (o_TX_Serial === e.pattern[b] && o_TX_Active_L === 1'b0 && o_TX_Done === 1'b0)
          matched++;
      end
      if (aborted) break;
      check_output($sformatf("bit%0d_cycles", b), matched, e.n);
    end
    if (aborted) begin
      check_output("abort_expected", 1, e.abort);
      check_output("abort_line_idle", {30'd0, o_TX_Serial, o_TX_Active_L}, 3);
      return;
    end
    check_output("abort_expected", 0, e.abort);
    @(negedge i_Clock);
    check_output("done_pulse", {29'd0, o_TX_Done, o_TX_Active_L, o_TX_Serial}, 7);
  endtask

  initial begin : monitor
    exp_frame_t e;
    forever begin
      @(negedge i_Clock);
      if (i_Rst_L && o_TX_Done) check_output("spurious_done", 1, 0);
      if (i_Rst_L && !o_TX_Active_L) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_frame", 1, 0);
          for (int k = 0; k < 50000 && !o_TX_Active_L; k++) @(negedge i_Clock);
        end else begin
          in_frame = 1;
          e = exp_q.pop_front();
          run_frame(e);
          in_frame = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int c0;
    exp_frame_t e;
    i_Rst_L       = 1'b0;
    i_TX_DV       = 1'b0;
    i_TX_Byte     = 8'h00;
    i_Clk_per_bit = 12'd1;
    repeat (2) @(posedge i_Clock);
    #1;
    check_output("reset_serial", {31'd0, o_TX_Serial}, 1);
    check_output("reset_active_l", {31'd0, o_TX_Active_L}, 1);
    check_output("reset_done", {31'd0, o_TX_Done}, 0);
    i_Rst_L = 1'b1;

    // 0xAF at 9600-baud period, DV held two clocks: exactly one frame
    apply_stimulus(8'hAF, 12'd3333, 2, 10'b1101011110, 3333, 0);
    wait_idle(40000);

    // 0xCD at N=4, inputs change mid-frame, then the new values go out
    apply_stimulus(8'hCD, 12'd4, 1, 10'b1110011010, 4, 0);
    repeat (15) @(posedge i_Clock);
    #1;
    i_TX_Byte     = 8'h54;
    i_Clk_per_bit = 12'd8;
    wait_idle(200);
    apply_stimulus(8'h54, 12'd8, 1, 10'b1010101000, 8, 0);
    wait_idle(200);

    // DV held high: three back-to-back frames, 21 clocks apart
    @(posedge i_Clock);
    #1;
    c0 = cyc;
    i_TX_Byte     = 8'hEB;
    i_Clk_per_bit = 12'd2;
    i_TX_DV       = 1'b1;
    for (int f = 0; f < 3; f++) begin
      e.pattern   = 10'b1111010110;
      e.n         = 2;
      e.start_cyc = c0 + 1 + 21 * f;
      e.abort     = 0;
      exp_q.push_back(e);
    end
    repeat (43) @(posedge i_Clock);
    #1;
    i_TX_DV = 1'b0;
    wait_idle(200);

    // Zero and one both mean a single-clock bit
    apply_stimulus(8'h01, 12'd0, 1, 10'b1000000010, 1, 0);
    wait_idle(50);
    apply_stimulus(8'h01, 12'd1, 1, 10'b1000000010, 1, 0);
    wait_idle(50);

    // Reset mid-frame: line high at once, no Done afterwards
    apply_stimulus(8'h5A, 12'd4, 1, 10'b1010110100, 4, 1);
    repeat (12) @(posedge i_Clock);
    #2;
    i_Rst_L = 1'b0;
    #1;
    check_output("midreset_serial", {31'd0, o_TX_Serial}, 1);
    check_output("midreset_active_l", {31'd0, o_TX_Active_L}, 1);
    check_output("midreset_done", {31'd0, o_TX_Done}, 0);
    repeat (2) @(posedge i_Clock);
    #1;
    i_Rst_L = 1'b1;
    wait_idle(50);
    repeat (40) @(posedge i_Clock);
    #1;
    check_output("post_abort_done", {31'd0, o_TX_Done}, 0);
    check_output("post_abort_serial", {31'd0, o_TX_Serial}, 1);
    check_output("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
